execute_mc: RTL

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/execute_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/execute_mc.sv
// execute_mc: execute stage with operand forwarding, ALU, branch target and an optional
// iterative multiply/divide unit, behind valid/ready handshakes on both sides.
module execute_mc #(
    parameter int XLEN   = 64,
    parameter int MDU_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            alusrc,
    input  logic [1:0]      aluop,
    input  logic [3:0]      funct4,
    input  logic            mdu_op,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] exmem_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_target,
    output logic            out_zero,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;
    state_t state_q, state_d;
    logic [XLEN-1:0] res_q, res_d, tgt_q, tgt_d, x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic remu_q, remu_d;
    logic [XLEN-1:0] op_a, op_b, alu_res, mul_acc_n, div_q_n, div_r_n;
    logic [XLEN:0] div_t, div_diff;
    logic [3:0] op;
    logic [SW-1:0] shamt;
    logic accept, mdu_go, div_ge, last;
    assign op_a = fwd_a == 2'b01 ? wb_data : fwd_a == 2'b10 ? exmem_data : rs1_data;
    assign op_b = alusrc ? imm : fwd_b == 2'b01 ? wb_data : fwd_b == 2'b10 ? exmem_data : rs2_data;
    assign op = aluop == 2'b10 ? funct4 : aluop == 2'b01 ? 4'b1000 : 4'b0000;
    assign shamt = op_b[SW-1:0];
    always_comb begin
        alu_res = op_b;
        if (aluop != 2'b11)
            case (op)
                4'b1000: alu_res = op_a - op_b;
                4'b0111: alu_res = op_a & op_b;
                4'b0110: alu_res = op_a | op_b;
                4'b0100: alu_res = op_a ^ op_b;
                4'b0001: alu_res = op_a << shamt;
                4'b0101: alu_res = op_a >> shamt;
                4'b1101: alu_res = $signed(op_a) >>> shamt;
                4'b0010: alu_res = XLEN'($signed(op_a) < $signed(op_b));
                4'b0011: alu_res = XLEN'(op_a < op_b);
                default: alu_res = op_a + op_b;
            endcase
    end
    assign in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
    assign accept = in_valid && in_ready;
    assign mdu_go = (MDU_EN != 0) && mdu_op;
    assign last = cnt_q == SW'(XLEN - 1);
    // MUL: x shifts left, y shifts right, acc accumulates. DIV: x holds dividend/quotient, acc the remainder.
    assign mul_acc_n = acc_q + (y_q[0] ? x_q : '0);
    assign div_t = {acc_q, x_q[XLEN-1]};
    assign div_diff = div_t - {1'b0, y_q};
    assign div_ge = !div_diff[XLEN];
    assign div_r_n = div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0];
    assign div_q_n = {x_q[XLEN-2:0], div_ge};
    always_comb begin
        state_d = state_q;
        res_d = res_q;
        tgt_d = tgt_q;
        x_d = x_q;
        y_d = y_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        remu_d = remu_q;
        if (accept) begin
            tgt_d = pc + (imm << 1);
            res_d = alu_res;
            x_d = op_a;
            y_d = op_b;
            acc_d = '0;
            cnt_d = '0;
            remu_d = funct4[1:0] == 2'b10;
            state_d = !mdu_go ? HOLD : funct4[2] ? DIV : MUL;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end else if (state_q == MUL || state_q == DIV) begin
            x_d = state_q == MUL ? x_q << 1 : div_q_n;
            y_d = state_q == MUL ? y_q >> 1 : y_q;
            acc_d = state_q == MUL ? mul_acc_n : div_r_n;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = HOLD;
                res_d = state_q == MUL ? mul_acc_n : remu_q ? div_r_n : div_q_n;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q <= '0;
            tgt_q <= '0;
            x_q <= '0;
            y_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            remu_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q <= res_d;
            tgt_q <= tgt_d;
            x_q <= x_d;
            y_q <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            remu_q <= remu_d;
        end
    end
    assign out_valid = state_q == HOLD;
    assign out_result = res_q;
    assign out_target = tgt_q;
    assign out_zero = out_valid && res_q == '0;
    assign busy = (MDU_EN != 0) && (state_q == MUL || state_q == DIV);
endmodule
